id_stage: RTL and testbench

- Instruction-decode stage of the 5-stage pipeline, directly downstream of the fetch stage.
- Consumes the fetched PC+4 and instruction word, and holds the 32x32 register file with its write-back port.
- Decodes control, detects RAW hazards against EX/MEM, and resolves branches in ID, driving br_taken/br_addr back to fetch.
- Registers everything into the ID/EX pipeline register.

---
 rtl/id_stage.sv | 168 ++++++++++++++++
 tb/tb_id_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction-decode stage: register file with write-back bypass, control
// decode, RAW hazard detection against EX/MEM, branch resolution in ID and
// the ID/EX pipeline register.
module id_stage #(
    parameter int REG_COUNT = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [31:0]       instr_in,
    input  logic              wb_en,
    input  logic [4:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_wb_en,
    input  logic              mem_wb_en,
    input  logic [4:0]        ex_dest,
    input  logic [4:0]        mem_dest,
    output logic              stall,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_addr,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] val1,
    output logic [DATA_W-1:0] val2,
    output logic [DATA_W-1:0] imm_ext,
    output logic [4:0]        dest,
    output logic [3:0]        exe_cmd,
    output logic              alu_imm,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              wb_en_out
);

    typedef struct packed {
        logic       rtype;
        logic       use1;
        logic       use2;
        logic       alu_imm;
        logic       mem_rd;
        logic       mem_wr;
        logic       wb;
        logic       bez;
        logic       bne;
        logic       jmp;
        logic       nop;
        logic [3:0] cmd;
    } dec_t;

    logic [5:0]        op;
    logic [4:0]        src1, rt, rd, dsel;
    logic [DATA_W-1:0] rf [REG_COUNT];
    logic [DATA_W-1:0] v1, v2, imm_x;
    logic              hz1, hz2, bubble;
    dec_t              d;

    assign op   = instr_in[31:26];
    assign src1 = instr_in[25:21];
    assign rt   = instr_in[20:16];
    assign rd   = instr_in[15:11];
    assign imm_x = {{(DATA_W-16){instr_in[15]}}, instr_in[15:0]};

    // Opcode decode; anything unrecognised falls through as a NOP
    always_comb begin
        d     = '0;
        d.cmd = 4'hF;
        d.nop = 1'b0;
        case (op)
            6'b000001: begin d.rtype = 1'b1; d.cmd = 4'b0000; end
            6'b000011: begin d.rtype = 1'b1; d.cmd = 4'b0010; end
            6'b000101: begin d.rtype = 1'b1; d.cmd = 4'b0100; end
            6'b000110: begin d.rtype = 1'b1; d.cmd = 4'b0101; end
            6'b000111: begin d.rtype = 1'b1; d.cmd = 4'b0110; end
            6'b001000: begin d.rtype = 1'b1; d.cmd = 4'b0111; end
            6'b001001: begin d.rtype = 1'b1; d.cmd = 4'b1000; end
            6'b001010: begin d.rtype = 1'b1; d.cmd = 4'b1000; end
            6'b001011: begin d.rtype = 1'b1; d.cmd = 4'b1001; end
            6'b001100: begin d.rtype = 1'b1; d.cmd = 4'b1010; end
            6'b100000: begin d.use1 = 1'b1; d.wb = 1'b1; d.alu_imm = 1'b1; d.cmd = 4'b0000; end
            6'b100001: begin d.use1 = 1'b1; d.wb = 1'b1; d.alu_imm = 1'b1; d.cmd = 4'b0010; end
            6'b100100: begin d.use1 = 1'b1; d.wb = 1'b1; d.alu_imm = 1'b1; d.mem_rd = 1'b1; d.cmd = 4'b0000; end
            6'b100101: begin d.use1 = 1'b1; d.use2 = 1'b1; d.alu_imm = 1'b1; d.mem_wr = 1'b1; d.cmd = 4'b0000; end
            6'b101000: begin d.use1 = 1'b1; d.bez = 1'b1; end
            6'b101001: begin d.use1 = 1'b1; d.use2 = 1'b1; d.bne = 1'b1; end
            6'b101010: d.jmp = 1'b1;
            default:   d.nop = 1'b1;
        endcase
        if (d.rtype) begin
            d.use1 = 1'b1;
            d.use2 = 1'b1;
            d.wb   = 1'b1;
        end
    end

    assign dsel = d.rtype ? rd : rt;

    // Register read with same-cycle write-back bypass; r0 is hardwired zero
    always_comb begin
        v1 = rf[src1];
        v2 = rf[rt];
        if (wb_en && wb_dest == src1) v1 = wb_data;
        if (wb_en && wb_dest == rt)   v2 = wb_data;
        if (src1 == 5'd0) v1 = '0;
        if (rt == 5'd0)   v2 = '0;
    end

    // RAW hazard against the producers still in EX and MEM
    always_comb begin
        hz1 = (src1 != 5'd0) && ((ex_wb_en && ex_dest == src1) || (mem_wb_en && mem_dest == src1));
        hz2 = (rt != 5'd0)   && ((ex_wb_en && ex_dest == rt)   || (mem_wb_en && mem_dest == rt));
    end

    assign stall = !rst && ((d.use1 && hz1) || (d.use2 && hz2));

    // Branch resolution; only trusted once operands are hazard-free
    assign br_taken = !rst && !stall &&
                      (d.jmp || (d.bez && v1 == '0) || (d.bne && v1 != v2));
    assign br_addr  = pc_in + (imm_x << 2);

    assign bubble = stall || br_taken || d.nop;

    // Register file: r0 is never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
        end else if (wb_en && wb_dest != 5'd0) begin
            rf[wb_dest] <= wb_data;
        end
    end

    // ID/EX pipeline register; hazards, taken branches and NOPs load a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out    <= '0;
            val1      <= '0;
            val2      <= '0;
            imm_ext   <= '0;
            dest      <= '0;
            exe_cmd   <= '0;
            alu_imm   <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            wb_en_out <= 1'b0;
        end else if (bubble) begin
            pc_out    <= '0;
            val1      <= '0;
            val2      <= '0;
            imm_ext   <= '0;
            dest      <= '0;
            exe_cmd   <= 4'hF;
            alu_imm   <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            wb_en_out <= 1'b0;
        end else begin
            pc_out    <= pc_in;
            val1      <= v1;
            val2      <= v2;
            imm_ext   <= imm_x;
            dest      <= dsel;
            exe_cmd   <= d.cmd;
            alu_imm   <= d.alu_imm;
            mem_rd    <= d.mem_rd;
            mem_wr    <= d.mem_wr;
            wb_en_out <= d.wb;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: expected ID/EX contents are queued when an
// instruction is driven and compared one cycle later.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in = '0, instr_in = '0, wb_data = '0;
    logic        wb_en = 1'b0, ex_wb_en = 1'b0, mem_wb_en = 1'b0;
    logic [4:0]  wb_dest = '0, ex_dest = '0, mem_dest = '0;
    logic        stall, br_taken, alu_imm, mem_rd, mem_wr, wb_en_out;
    logic [31:0] br_addr, pc_out, val1, val2, imm_ext;
    logic [4:0]  dest;
    logic [3:0]  exe_cmd;

    id_stage dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
        .ex_wb_en(ex_wb_en), .mem_wb_en(mem_wb_en),
        .ex_dest(ex_dest), .mem_dest(mem_dest),
        .stall(stall), .br_taken(br_taken), .br_addr(br_addr),
        .pc_out(pc_out), .val1(val1), .val2(val2), .imm_ext(imm_ext),
        .dest(dest), .exe_cmd(exe_cmd), .alu_imm(alu_imm),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .wb_en_out(wb_en_out)
    );

    always #5 clk = ~clk;

    // mode: 0 no check, 1 control enables, 2 + exe_cmd, 3 every field
    typedef struct {
        int          mode;
        logic [31:0] pc, v1, v2, imm;
        logic [4:0]  dst;
        logic [3:0]  cmd;
        logic        ai, mrd, mwr, wb;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(int mode, logic [31:0] pc, logic [31:0] v1, logic [31:0] v2,
                                logic [31:0] imm, logic [4:0] dst, logic [3:0] cmd,
                                logic ai, logic mrd, logic mwr, logic wb);
        exp_t e;
        e.mode = mode; e.pc = pc; e.v1 = v1; e.v2 = v2; e.imm = imm;
        e.dst = dst; e.cmd = cmd; e.ai = ai; e.mrd = mrd; e.mwr = mwr; e.wb = wb;
        return e;
    endfunction

    function automatic exp_t bub();
        return mk(3, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0);
    endfunction

    function automatic logic [31:0] rt_i(logic [5:0] op, logic [4:0] s1, logic [4:0] s2, logic [4:0] d);
        return {op, s1, s2, d, 11'd0};
    endfunction

    function automatic logic [31:0] it_i(logic [5:0] op, logic [4:0] s1, logic [4:0] d, logic [15:0] imm);
        return {op, s1, d, imm};
    endfunction

    task automatic drive(input logic [31:0] pc, input logic [31:0] ins);
        pc_in = pc;
        instr_in = ins;
    endtask

    task automatic cmb(input string tag, input logic st, input logic br);
        #1;
        chk({tag, ".stall"}, {31'd0, stall}, {31'd0, st});
        chk({tag, ".br_taken"}, {31'd0, br_taken}, {31'd0, br});
    endtask

    task automatic step(input string tag, input exp_t e);
        exp_t g;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        if (g.mode >= 1) begin
            chk({tag, ".wb_en_out"}, {31'd0, wb_en_out}, {31'd0, g.wb});
            chk({tag, ".mem_rd"}, {31'd0, mem_rd}, {31'd0, g.mrd});
            chk({tag, ".mem_wr"}, {31'd0, mem_wr}, {31'd0, g.mwr});
        end
        if (g.mode >= 2) chk({tag, ".exe_cmd"}, {28'd0, exe_cmd}, {28'd0, g.cmd});
        if (g.mode >= 3) begin
            chk({tag, ".pc_out"}, pc_out, g.pc);
            chk({tag, ".val1"}, val1, g.v1);
            chk({tag, ".val2"}, val2, g.v2);
            chk({tag, ".imm_ext"}, imm_ext, g.imm);
            chk({tag, ".dest"}, {27'd0, dest}, {27'd0, g.dst});
            chk({tag, ".alu_imm"}, {31'd0, alu_imm}, {31'd0, g.ai});
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".pc_out"}, pc_out, 0);
        chk({tag, ".val1"}, val1, 0);
        chk({tag, ".val2"}, val2, 0);
        chk({tag, ".imm_ext"}, imm_ext, 0);
        chk({tag, ".dest"}, {27'd0, dest}, 0);
        chk({tag, ".exe_cmd"}, {28'd0, exe_cmd}, 0);
        chk({tag, ".ctl"}, {28'd0, alu_imm, mem_rd, mem_wr, wb_en_out}, 0);
        chk({tag, ".stall"}, {31'd0, stall}, 0);
        chk({tag, ".br_taken"}, {31'd0, br_taken}, 0);
    endtask

    logic [5:0] alu_op  [10] = '{6'h01, 6'h03, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C};
    logic [3:0] alu_cmd [10] = '{4'h0, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h8, 4'h9, 4'hA};

    initial begin
        #2;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // r1 = 1546 while a NOP is decoded
        wb_en = 1; wb_dest = 1; wb_data = 32'd1546;
        drive(32'h0, 32'h0);
        step("nop_wb", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        wb_en = 0;
        drive(32'h10, rt_i(6'h01, 0, 1, 2));
        cmb("add", 0, 0);
        step("add", mk(3, 32'h10, 0, 1546, 32'h1000, 2, 4'h0, 0, 0, 0, 1));

        // Same-cycle bypass: r3 = 7 written while SUB r4,r3,r3 reads it
        wb_en = 1; wb_dest = 3; wb_data = 32'd7;
        drive(32'h14, rt_i(6'h03, 3, 3, 4));
        cmb("sub_byp", 0, 0);
        step("sub_byp", mk(3, 32'h14, 7, 7, 32'h2000, 4, 4'h2, 0, 0, 0, 1));
        wb_en = 0;

        // EX hazard on src1, then cleared
        ex_wb_en = 1; ex_dest = 5;
        drive(32'h18, rt_i(6'h06, 5, 0, 6));
        cmb("or_haz", 1, 0);
        step("or_haz", bub());
        ex_wb_en = 0;
        cmb("or_clr", 0, 0);
        step("or_clr", mk(3, 32'h18, 0, 0, 32'h3000, 6, 4'h5, 0, 0, 0, 1));

        // MEM hazard on src2 operand
        mem_wb_en = 1; mem_dest = 3;
        drive(32'h1C, rt_i(6'h03, 0, 3, 4));
        cmb("sub_memhaz", 1, 0);
        step("sub_memhaz", bub());
        mem_wb_en = 0;

        // r0 as source never stalls, even when EX targets r0
        ex_wb_en = 1; ex_dest = 0;
        drive(32'h20, rt_i(6'h06, 0, 0, 6));
        cmb("r0_src", 0, 0);
        step("r0_src", mk(3, 32'h20, 0, 0, 32'h3000, 6, 4'h5, 0, 0, 0, 1));

        // JMP does not use src1; stalled BEZ must not redirect
        ex_dest = 5;
        drive(32'h40, it_i(6'h2A, 5, 0, 16'd3));
        cmb("jmp_nohaz", 0, 1);
        chk("jmp.br_addr", br_addr, 32'h4C);
        step("jmp", mk(2, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0));
        drive(32'h40, it_i(6'h28, 5, 0, 16'hFFFE));
        cmb("bez_stall", 1, 0);
        step("bez_stall", bub());
        ex_wb_en = 0;

        // Branches at pc 0x40, imm -2
        drive(32'h40, it_i(6'h28, 0, 0, 16'hFFFE));
        cmb("bez_r0", 0, 1);
        chk("bez_r0.br_addr", br_addr, 32'h38);
        step("bez_r0", mk(2, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0));
        drive(32'h40, it_i(6'h29, 1, 1, 16'hFFFE));
        cmb("bne_eq", 0, 0);
        chk("bne_eq.br_addr", br_addr, 32'h38);
        step("bne_eq", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(32'h40, it_i(6'h29, 1, 2, 16'hFFFE));
        cmb("bne_ne", 0, 1);
        step("bne_ne", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(32'h40, it_i(6'h28, 1, 0, 16'hFFFE));
        cmb("bez_nz", 0, 0);
        step("bez_nz", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Write to r0 is discarded and not bypassed
        wb_en = 1; wb_dest = 0; wb_data = 32'hFFFF;
        drive(32'h50, it_i(6'h20, 0, 1, 16'd10));
        step("addi", mk(3, 32'h50, 0, 1546, 32'd10, 1, 4'h0, 1, 0, 0, 1));
        wb_en = 0;
        drive(32'h54, it_i(6'h20, 0, 7, 16'h8000));
        step("addi_neg", mk(3, 32'h54, 0, 0, 32'hFFFF8000, 7, 4'h0, 1, 0, 0, 1));

        drive(32'h58, it_i(6'h24, 1, 8, 16'd4));
        step("ld", mk(3, 32'h58, 1546, 0, 32'd4, 8, 4'h0, 1, 1, 0, 1));
        drive(32'h5C, it_i(6'h25, 1, 3, 16'd8));
        step("st", mk(3, 32'h5C, 1546, 7, 32'd8, 3, 4'h0, 1, 0, 1, 0));
        ex_wb_en = 1; ex_dest = 3;
        cmb("st_haz", 1, 0);
        step("st_haz", bub());
        ex_wb_en = 0;

        drive(32'h60, 32'hFC00_0000);
        step("undef", mk(2, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0));

        for (int i = 0; i < 10; i++) begin
            drive(32'h100 + i * 4, rt_i(alu_op[i], 1, 3, 9));
            step("alu_tbl", mk(3, 32'h100 + i * 4, 1546, 7, 32'h4800, 9, alu_cmd[i], 0, 0, 0, 1));
        end

        // Reset in the middle of a stall
        ex_wb_en = 1; ex_dest = 1;
        drive(32'h70, rt_i(6'h01, 1, 0, 2));
        cmb("pre_rst", 1, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero("mid_rst");
        ex_wb_en = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i < 32; i++) begin
            drive(i * 4, rt_i(6'h06, i[4:0], i[4:0], 0));
            step("rf_clr", mk(3, i * 4, 0, 0, 0, 0, 4'h5, 0, 0, 0, 1));
        end

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
